keypad_decoder: RTL and testbench

KEYPAD_DECODER -- requirements
Module: keypad_decoder

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/sync2.sv | 35 +++
 rtl/keypad_decoder.sv | 163 ++++++++++++++++
 tb/tb_keypad_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared FSM state type and 4x4 key map for the keypad decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    // Indexed [row][col]; row 3 occupies the top 16 bits, col 3 the top nibble of each row.
    localparam logic [3:0][3:0][3:0] c_key_map = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for asynchronous inputs, with reset value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_decoder.sv
// ============================================================================
// Module   : keypad_decoder
// Purpose  : Debounced 4x4 scanned-keypad decoder, single key, no rollover.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_drive,
    input  logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    logic [3:0]       w_rows_sync;
    logic [3:0]       r_col_d1, r_col_d2;
    logic [1:0]       w_col_idx, w_row_idx;
    logic             w_col_ok, w_row_ok, w_hit;
    logic             w_on_col, w_key_up, w_key_down;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_cap_row, w_cap_row_nxt;
    logic [1:0]       r_cap_col, w_cap_col_nxt;
    logic             r_key_valid, w_valid_nxt;
    logic [3:0]       r_key_code, w_code_nxt;
    logic             r_key_held, w_held_nxt;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rows),
        .o_q   (w_rows_sync)
    );

    // Column strobe is delayed to line up with the synchronized row sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_d1 <= 4'b0000;
            r_col_d2 <= 4'b0000;
        end else begin
            r_col_d1 <= col_drive;
            r_col_d2 <= r_col_d1;
        end
    end

    always_comb begin
        w_col_idx = 2'd0;
        w_col_ok  = 1'b0;
        case (r_col_d2)
            4'b0001: begin w_col_idx = 2'd0; w_col_ok = 1'b1; end
            4'b0010: begin w_col_idx = 2'd1; w_col_ok = 1'b1; end
            4'b0100: begin w_col_idx = 2'd2; w_col_ok = 1'b1; end
            4'b1000: begin w_col_idx = 2'd3; w_col_ok = 1'b1; end
            default: ;
        endcase
        w_row_idx = 2'd0;
        w_row_ok  = 1'b0;
        case (w_rows_sync)
            4'b1110: begin w_row_idx = 2'd0; w_row_ok = 1'b1; end
            4'b1101: begin w_row_idx = 2'd1; w_row_ok = 1'b1; end
            4'b1011: begin w_row_idx = 2'd2; w_row_ok = 1'b1; end
            4'b0111: begin w_row_idx = 2'd3; w_row_ok = 1'b1; end
            default: ;
        endcase
    end

    assign w_hit      = w_col_ok & w_row_ok;
    assign w_on_col   = w_col_ok && (w_col_idx == r_cap_col);
    assign w_key_up   = w_on_col &&  w_rows_sync[r_cap_row];
    assign w_key_down = w_on_col && !w_rows_sync[r_cap_row];
    assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cap_row_nxt = r_cap_row;
        w_cap_col_nxt = r_cap_col;
        w_valid_nxt   = 1'b0;
        w_code_nxt    = r_key_code;
        w_held_nxt    = r_key_held;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_cap_row_nxt = w_row_idx;
                    w_cap_col_nxt = w_col_idx;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = PRESS_DB;
                end
            end
            PRESS_DB: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_key_up) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_cnt_last) begin
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = c_key_map[r_cap_row][r_cap_col];
                    w_held_nxt  = 1'b1;
                    w_state_nxt = HELD;
                end
            end
            HELD: begin
                if (w_key_up) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_DB;
                end
            end
            RELEASE_DB: begin
                w_cnt_nxt = w_cnt_inc;
                // A re-press of the same key wins over an expiring release count.
                if (w_key_down) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == c_cnt_last) begin
                    w_held_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cap_row   <= 2'd0;
            r_cap_col   <= 2'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cap_row   <= w_cap_row_nxt;
            r_cap_col   <= w_cap_col_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_code  <= w_code_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;

endmodule

`default_nettype wire

// File: tb/tb_keypad_decoder.sv
// ============================================================================
// Module   : tb_keypad_decoder
// Purpose  : Directed self-checking bench for keypad_decoder (DEBOUNCE_CYCLES=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_decoder;
    import keypad_pkg::*;

    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_drive = 4'b0000;
    logic [3:0] rows = 4'hF;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_decoder #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_drive (col_drive),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    int         tests = 0;
    int         fails = 0;
    logic [15:0] keys_down = 16'h0000;   // bit row*4+col set = key pressed
    logic       fixed_en = 1'b0;
    logic [3:0] fixed_rows = 4'hF;
    logic [1:0] col_idx = 2'd3;
    int         cyc = 0;
    int         pulses = 0;
    int         first_hit = -1;
    int         first_valid = -1;
    logic       held_dropped = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan cycle: rotate column, drive rows from the pressed-key set, sample after the edge.
    task automatic tick();
        @(negedge clk);
        col_idx   = col_idx + 2'd1;
        col_drive = 4'b0001 << col_idx;
        rows      = 4'hF;
        if (fixed_en) begin
            rows = fixed_rows;
        end else begin
            for (int r = 0; r < 4; r++)
                if (keys_down[r*4 + int'(col_idx)]) rows[r] = 1'b0;
        end
        if (first_hit < 0 && !reset && rows != 4'hF) first_hit = cyc;
        @(posedge clk);
        #1;
        if (key_valid) begin
            pulses++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (!key_held) held_dropped = 1'b1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic trk();
        pulses       = 0;
        first_hit    = -1;
        first_valid  = -1;
        held_dropped = 1'b0;
    endtask

    // Advance until the next tick drives column tgt.
    task automatic align(input logic [1:0] tgt);
        for (int i = 0; i < 4; i++)
            if (col_idx != tgt - 2'd1) tick();
    endtask

    function automatic int kb(input int r, input int c);
        return r*4 + c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        run(3);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code",  32'(key_code),  32'h0);
        check("rst_held",  32'(key_held),  32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        reset = 1'b0;

        // Key 2: row0 low only on column 1
        trk();
        keys_down[kb(0, 1)] = 1'b1;
        run(20);
        check("k2_pulses",  32'(pulses),   32'd1);
        check("k2_code",    32'(key_code), 32'h2);
        check("k2_held",    32'(key_held), 32'd1);
        check("k2_latency", 32'(first_valid - first_hit), 32'(2 + DB));
        keys_down = '0;
        run(14);
        check("k2_release_held", 32'(key_held), 32'd0);

        // Key 7 with one bounce scan, then a steady press
        trk();
        keys_down[kb(2, 0)] = 1'b1;
        run(4);
        keys_down = '0;
        run(12);
        check("bounce_pulses", 32'(pulses),        32'd0);
        check("bounce_state",  32'(dut.r_state),   32'(IDLE));
        check("bounce_held",   32'(key_held),      32'd0);
        trk();
        keys_down[kb(2, 0)] = 1'b1;
        run(20);
        check("k7_pulses",  32'(pulses),   32'd1);
        check("k7_code",    32'(key_code), 32'h7);
        check("k7_latency", 32'(first_valid - first_hit), 32'(2 + DB));
        keys_down = '0;
        run(14);
        check("k7_release_held", 32'(key_held), 32'd0);

        // Key 5 held, key 9 added: no rollover
        trk();
        keys_down[kb(1, 1)] = 1'b1;
        run(20);
        check("k5_pulses", 32'(pulses),   32'd1);
        check("k5_code",   32'(key_code), 32'h5);
        keys_down[kb(2, 2)] = 1'b1;
        run(16);
        check("k5k9_pulses", 32'(pulses),   32'd1);
        check("k5k9_code",   32'(key_code), 32'h5);
        check("k5k9_held",   32'(key_held), 32'd1);
        keys_down = '0;
        run(14);
        check("k5_release_held",  32'(key_held),    32'd0);
        check("k5_release_state", 32'(dut.r_state), 32'(IDLE));

        // Two rows low on every column: never a hit
        trk();
        fixed_en   = 1'b1;
        fixed_rows = 4'b1100;
        run(12);
        check("multi_pulses", 32'(pulses),        32'd0);
        check("multi_state",  32'(dut.r_state),   32'(IDLE));
        check("multi_code",   32'(key_code),      32'h5);
        fixed_en = 1'b0;
        run(4);

        // Key 3: short release while held, then re-press
        trk();
        keys_down[kb(0, 2)] = 1'b1;
        run(20);
        check("k3_pulses", 32'(pulses),   32'd1);
        check("k3_code",   32'(key_code), 32'h3);
        align(2'd2);
        trk();
        keys_down = '0;
        run(3);
        keys_down[kb(0, 2)] = 1'b1;
        run(12);
        check("k3_glitch_held",   32'(held_dropped), 32'd0);
        check("k3_glitch_pulses", 32'(pulses),       32'd0);
        check("k3_glitch_state",  32'(dut.r_state),  32'(HELD));
        keys_down = '0;
        run(14);
        check("k3_release_held", 32'(key_held), 32'd0);

        // Key D: reset at counter=6 aborts, then steady press decodes
        align(2'd3);
        trk();
        keys_down[kb(3, 3)] = 1'b1;
        run(9);
        check("kd_prereset_pulses", 32'(pulses), 32'd0);
        reset = 1'b1;
        tick();
        check("kd_rst_valid", 32'(key_valid),   32'd0);
        check("kd_rst_code",  32'(key_code),    32'h0);
        check("kd_rst_held",  32'(key_held),    32'd0);
        check("kd_rst_state", 32'(dut.r_state), 32'(IDLE));
        reset = 1'b0;
        trk();
        run(20);
        check("kd_pulses",  32'(pulses),   32'd1);
        check("kd_code",    32'(key_code), 32'hD);
        check("kd_held",    32'(key_held), 32'd1);
        check("kd_latency", 32'(first_valid - first_hit), 32'(2 + DB));
        keys_down = '0;
        run(14);
        check("kd_release_held", 32'(key_held), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
